// File: rtl/aes_uart_pkg.sv
// Shared types and constants for the UART-to-AES frame assemblers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the cipher block width, the default header bytes, the byte-counter
// width and the assembler state encoding shared by the encrypt-side and
// decrypt-side assemblers.
package aes_uart_pkg;

    localparam int AES_BLOCK_W = 128;

    // Bytes in one frame payload, and the counter that walks them.
    localparam int PAYLOAD_BYTES = AES_BLOCK_W / 8;
    localparam int BYTE_CNT_W    = $clog2(PAYLOAD_BYTES);

    // The last payload byte never sits in the assembly register. It is
    // concatenated straight onto the output, so the register only needs
    // the first fifteen bytes.
    localparam int ASM_W = AES_BLOCK_W - 8;

    localparam logic [7:0] KEY_HDR_DEFAULT  = 8'h4B;   // 'K'
    localparam logic [7:0] DATA_HDR_DEFAULT = 8'h44;   // 'D'

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        KEY_PL  = 2'd1,
        DATA_PL = 2'd2,
        HOLD    = 2'd3
    } state_t;

endpackage

// File: rtl/aes_rx_timeout.sv
// Inter-byte idle timer: counts enabled cycles since the last clear.
// Latency: expire is combinational from the count and is high in the cycle
//          the count sits at CYCLES-1.
// Backpressure: none. The owner decides what to do with expire.
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : restart the count from zero at the next edge (wins over en)
//   en         : count this cycle. When low, the count holds.
//   expire     : high while enabled, not cleared, and the count is CYCLES-1
module aes_rx_timeout #(
    parameter int CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // After firing, the count wraps to zero. A caller that stays enabled
    // then gets another full interval rather than a stuck expire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // A clear in the same cycle suppresses expiry: a byte arriving on the
    // deadline keeps the frame alive.
    assign expire = en && !clr && (cnt == LAST);

endmodule

// File: rtl/aes_uart_frame_assembler.sv
// Assembles header + 16-byte UART frames into an AES key or a 128-bit data block.
// Latency: the 16th payload byte strobed in cycle N gives key_out/key_update or
//          blk_valid/blk_data in cycle N+1.
// Backpressure: blk_valid holds until blk_ready. Bytes arriving meanwhile are
//               dropped with a frame_err pulse.
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   rx_data, rx_valid    : received byte and its one-cycle strobe
//   key_out, key_update  : current cipher key and its one-cycle change pulse
//   blk_data, blk_valid  : assembled data block and its valid flag
//   blk_ready            : downstream cipher accepts the block
//   frame_err            : one-cycle pulse on bad header, timeout or overrun
//   busy                 : high whenever the assembler is not idle
module aes_uart_frame_assembler
    import aes_uart_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0] KEY_HDR        = KEY_HDR_DEFAULT,
    parameter logic [7:0] DATA_HDR       = DATA_HDR_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [AES_BLOCK_W-1:0] key_out,
    output logic                   key_update,
    output logic [AES_BLOCK_W-1:0] blk_data,
    output logic                   blk_valid,
    input  logic                   blk_ready,
    output logic                   frame_err,
    output logic                   busy
);

    state_t                state;
    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic [ASM_W-1:0]      asm_reg;
    logic [AES_BLOCK_W-1:0] frame_word;
    logic                  last_byte;
    logic                  in_payload;
    logic                  tmo_clr;
    logic                  tmo_expire;

    // The first byte ends up in [127:120] after fifteen shifts. The 16th
    // byte lands directly in [7:0].
    assign frame_word = {asm_reg, rx_data};
    assign last_byte  = (byte_cnt == BYTE_CNT_W'(PAYLOAD_BYTES - 1));
    assign in_payload = (state == KEY_PL) || (state == DATA_PL);

    // Any byte the FSM consumes restarts the idle timer. Bytes discarded in
    // HOLD do not count, because the timer is idle there anyway.
    assign tmo_clr = rx_valid && (state != HOLD);

    aes_rx_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmo_clr),
        .en     (in_payload),
        .expire (tmo_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            asm_reg    <= '0;
            key_out    <= '0;
            key_update <= 1'b0;
            blk_data   <= '0;
            blk_valid  <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            key_update <= 1'b0;
            frame_err  <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == KEY_HDR) begin
                            state    <= KEY_PL;
                            byte_cnt <= '0;
                            busy     <= 1'b1;
                        end else if (rx_data == DATA_HDR) begin
                            state    <= DATA_PL;
                            byte_cnt <= '0;
                            busy     <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end

                KEY_PL, DATA_PL: begin
                    // A byte on the expiry cycle takes priority over the timeout.
                    if (rx_valid) begin
                        asm_reg  <= {asm_reg[ASM_W-9:0], rx_data};
                        byte_cnt <= byte_cnt + 1'b1;   // 15 wraps to 0
                        if (last_byte) begin
                            if (state == KEY_PL) begin
                                // key_out only ever sees a complete frame.
                                key_out    <= frame_word;
                                key_update <= 1'b1;
                                state      <= IDLE;
                                busy       <= 1'b0;
                            end else begin
                                blk_data  <= frame_word;
                                blk_valid <= 1'b1;
                                state     <= HOLD;
                            end
                        end
                    end else if (tmo_expire) begin
                        frame_err <= 1'b1;
                        byte_cnt  <= '0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end

                HOLD: begin
                    // The held block is never overwritten. A byte arriving
                    // now is lost and flagged.
                    if (rx_valid) begin
                        frame_err <= 1'b1;
                    end
                    if (blk_valid && blk_ready) begin
                        blk_valid <= 1'b0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_uart_frame_assembler.sv
// Scoreboard bench for aes_uart_frame_assembler.
// Stimulus pushes expected key/block/error events, each tagged with the cycle it
// should appear in. A negedge monitor pops and compares them against DUT outputs.
module tb_aes_uart_frame_assembler;

    logic         clk;
    logic         rst_n;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [127:0] key_out;
    logic         key_update;
    logic [127:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic         frame_err;
    logic         busy;

    aes_uart_frame_assembler #(
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .key_out    (key_out),
        .key_update (key_update),
        .blk_data   (blk_data),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pc counts rising edges. A byte driven while pc==p is captured at edge
    // p+1, and its registered result is visible at the negedge with pc==p+1.
    int pc = 0;
    always @(posedge clk) pc <= pc + 1;

    typedef struct {
        logic [127:0] dat;
        int           pc;
    } exp_t;

    exp_t key_q[$];
    exp_t blk_q[$];
    int   err_q[$];

    int errors = 0;
    int checks = 0;
    int last_pc = 0;

    task automatic check(input bit ok, input string name,
                         input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every event the DUT presents against the scoreboard.
    bit hs_prev  = 1'b0;
    bit vld_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        int   ep;
        if (!rst_n) begin
            hs_prev  = 1'b0;
            vld_prev = 1'b0;
        end else begin
            if (key_update) begin
                if (key_q.size() == 0) begin
                    check(1'b0, "key_update_unexpected", 128'(pc), 128'(0));
                end else begin
                    e = key_q.pop_front();
                    check(key_out == e.dat, "key_value", key_out, e.dat);
                    check(pc == e.pc, "key_cycle", 128'(pc), 128'(e.pc));
                end
            end
            if (frame_err) begin
                if (err_q.size() == 0) begin
                    check(1'b0, "frame_err_unexpected", 128'(pc), 128'(0));
                end else begin
                    ep = err_q.pop_front();
                    check(pc == ep, "frame_err_cycle", 128'(pc), 128'(ep));
                end
            end
            if (hs_prev) begin
                check(blk_valid == 1'b0, "blk_valid_drop", 128'(blk_valid), 128'(0));
            end
            if (blk_valid) begin
                if (blk_q.size() == 0) begin
                    check(1'b0, "blk_valid_unexpected", 128'(pc), 128'(0));
                end else begin
                    if (!vld_prev) begin
                        check(pc == blk_q[0].pc, "blk_cycle", 128'(pc), 128'(blk_q[0].pc));
                    end
                    check(blk_data == blk_q[0].dat, "blk_data", blk_data, blk_q[0].dat);
                    if (blk_ready) begin
                        e = blk_q.pop_front();
                    end
                end
            end
            hs_prev  = blk_valid && blk_ready;
            vld_prev = blk_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        last_pc  = pc;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic push_key(input logic [127:0] k, input int at);
        exp_t e;
        e.dat = k;
        e.pc  = at;
        key_q.push_back(e);
    endtask

    task automatic push_blk(input logic [127:0] d, input int at);
        exp_t e;
        e.dat = d;
        e.pc  = at;
        blk_q.push_back(e);
    endtask

    // Watchdog: the stimulus has no open-ended waits, but never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        rst_n     = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        blk_ready = 1'b0;
        repeat (3) tick();

        // Reset state
        check(key_out == 0, "rst_key_out", key_out, 0);
        check(blk_data == 0, "rst_blk_data", blk_data, 0);
        check({key_update, blk_valid, frame_err, busy} == 4'b0,
              "rst_flags", 128'({key_update, blk_valid, frame_err, busy}), 0);
        rst_n = 1'b1;
        tick();

        // Key frame 00..0f
        send(8'h4B);
        check(busy == 1'b1, "busy_in_frame", 128'(busy), 1);
        for (int i = 0; i < 16; i++) send(8'(i));
        push_key(128'h000102030405060708090a0b0c0d0e0f, last_pc + 1);
        repeat (2) tick();
        check(busy == 1'b0, "busy_after_key", 128'(busy), 0);

        // Data frame 00 11 .. ff, held 20 cycles, overrun byte in HOLD
        send(8'h44);
        for (int i = 0; i < 16; i++) send(8'(i * 17));
        push_blk(128'h00112233445566778899aabbccddeeff, last_pc + 1);
        repeat (10) tick();
        send(8'h99);
        err_q.push_back(last_pc + 1);
        repeat (9) tick();
        check(busy == 1'b1, "busy_in_hold", 128'(busy), 1);
        blk_ready = 1'b1;
        tick();
        blk_ready = 1'b0;
        tick();
        check(busy == 1'b0, "busy_after_hold", 128'(busy), 0);

        // Timeout after 8 bytes of a key frame: error, key unchanged
        send(8'h4B);
        for (int i = 0; i < 8; i++) send(8'hC0 + 8'(i));
        p = last_pc;
        err_q.push_back(p + 51);
        while (pc < p + 56) tick();
        check(key_out == 128'h000102030405060708090a0b0c0d0e0f, "key_after_timeout",
              key_out, 128'h000102030405060708090a0b0c0d0e0f);
        check(busy == 1'b0, "busy_after_timeout", 128'(busy), 0);

        // Byte exactly on the expiry cycle: frame continues
        send(8'h4B);
        for (int i = 0; i < 8; i++) send(8'hA0 + 8'(i));
        p = last_pc;
        while (pc < p + 50) tick();
        for (int i = 8; i < 16; i++) send(8'hA0 + 8'(i));
        push_key(128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf, last_pc + 1);
        repeat (2) tick();

        // Bad header in IDLE
        send(8'h41);
        err_q.push_back(last_pc + 1);
        tick();
        check(busy == 1'b0, "busy_after_bad_hdr", 128'(busy), 0);

        // Reset mid key frame, then a clean key frame
        send(8'h4B);
        for (int i = 0; i < 10; i++) send(8'h55);
        rst_n = 1'b0;
        tick();
        check(key_out == 0, "key_in_reset", key_out, 0);
        check(busy == 1'b0, "busy_in_reset", 128'(busy), 0);
        tick();
        rst_n = 1'b1;
        tick();
        send(8'h4B);
        for (int i = 0; i < 16; i++) send(8'h30 + 8'(i));
        push_key(128'h303132333435363738393a3b3c3d3e3f, last_pc + 1);
        repeat (2) tick();

        // Data frame with ready held high, next header right after transfer
        blk_ready = 1'b1;
        send(8'h44);
        for (int i = 0; i < 16; i++) send(8'h80 + 8'(i));
        push_blk(128'h808182838485868788898a8b8c8d8e8f, last_pc + 1);
        tick();
        send(8'h4B);
        for (int i = 0; i < 16; i++) send(8'h10 + 8'(i));
        push_key(128'h101112131415161718191a1b1c1d1e1f, last_pc + 1);
        blk_ready = 1'b0;
        repeat (5) tick();

        check(key_q.size() == 0, "key_events_left", 128'(key_q.size()), 0);
        check(blk_q.size() == 0, "blk_events_left", 128'(blk_q.size()), 0);
        check(err_q.size() == 0, "err_events_left", 128'(err_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
